// File: rtl/rr_mux2_stream.sv
// rtl/rr_mux2_stream.sv - two-input round-robin stream arbiter with registered 2:1 mux output
// Optional packet lock (grant held until last beat) enabled by ARB_PKT_LOCK_EN.
module rr_mux2_stream #(
  parameter int WIDTH        = 8,
  parameter bit PRIO_B_FIRST = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             a_valid,
  input  logic [WIDTH-1:0] a_data,
`ifdef ARB_PKT_LOCK_EN
  input  logic             a_last,
`endif
  output logic             a_ready,
  input  logic             b_valid,
  input  logic [WIDTH-1:0] b_data,
`ifdef ARB_PKT_LOCK_EN
  input  logic             b_last,
`endif
  output logic             b_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             out_sel,
  input  logic             out_ready
);

  localparam logic ST_EMPTY = 1'b0;
  localparam logic ST_FULL  = 1'b1;

  logic             state;
  logic             prio;
  logic             load;
  logic             accept;
  logic             grant_vld;
  logic             grant_sel;
  logic [WIDTH-1:0] data_q;
  logic             sel_q;

`ifdef ARB_PKT_LOCK_EN
  logic locked;
  logic lock_sel;
  logic beat_last;

  assign beat_last = grant_sel ? b_last : a_last;
`endif

  // prio only breaks ties; a lone valid source always wins
  always_comb begin
    grant_vld = a_valid || b_valid;
    grant_sel = (a_valid && b_valid) ? prio : b_valid;
`ifdef ARB_PKT_LOCK_EN
    if (locked) begin
      grant_vld = lock_sel ? b_valid : a_valid;
      grant_sel = lock_sel;
    end
`endif
  end

  assign load   = (state == ST_EMPTY) || out_ready;
  assign accept = load && grant_vld;

  // readies are held low while reset is asserted so no beat is dropped
  assign a_ready = rst_n && accept && !grant_sel;
  assign b_ready = rst_n && accept && grant_sel;

  assign out_valid = (state == ST_FULL);
  assign out_data  = data_q;
  assign out_sel   = sel_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_EMPTY;
      data_q <= '0;
      sel_q  <= 1'b0;
      prio   <= PRIO_B_FIRST;
`ifdef ARB_PKT_LOCK_EN
      locked   <= 1'b0;
      lock_sel <= 1'b0;
`endif
    end else if (accept) begin
      state  <= ST_FULL;
      data_q <= grant_sel ? b_data : a_data;
      sel_q  <= grant_sel;
`ifdef ARB_PKT_LOCK_EN
      if (beat_last) begin
        prio <= !grant_sel;
      end
      locked   <= !beat_last;
      lock_sel <= grant_sel;
`else
      prio <= !grant_sel;
`endif
    end else if (load) begin
      state <= ST_EMPTY;
    end
  end

endmodule

// File: tb/tb_rr_mux2_stream.sv
// tb/tb_rr_mux2_stream.sv - scoreboard bench for rr_mux2_stream with random and directed stimulus
module tb_rr_mux2_stream;
  localparam int WIDTH = 8;
  localparam bit PRIO  = 1'b0;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             a_valid = 1'b0;
  logic [WIDTH-1:0] a_data = '0;
  logic             a_ready;
  logic             b_valid = 1'b0;
  logic [WIDTH-1:0] b_data = '0;
  logic             b_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_sel;
  logic             out_ready = 1'b0;

  always #5 clk = ~clk;

  rr_mux2_stream #(.WIDTH(WIDTH), .PRIO_B_FIRST(PRIO)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .a_valid  (a_valid),
    .a_data   (a_data),
`ifdef ARB_PKT_LOCK_EN
    .a_last   (1'b1),
`endif
    .a_ready  (a_ready),
    .b_valid  (b_valid),
    .b_data   (b_data),
`ifdef ARB_PKT_LOCK_EN
    .b_last   (1'b1),
`endif
    .b_ready  (b_ready),
    .out_valid(out_valid),
    .out_data (out_data),
    .out_sel  (out_sel),
    .out_ready(out_ready)
  );

  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic             sel;
  } beat_t;

  int    n_checks = 0;
  int    n_fail   = 0;
  beat_t exp_q[$];
  int    rd_idx   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: an occupancy flag plus "whose turn it is on a tie".
  bit m_full;
  bit m_turn_b;
  bit m_load;
  bit m_has_win;
  bit m_win_b;

  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_full   = 1'b0;
      m_turn_b = PRIO;
    end else begin
      m_load    = !m_full || out_ready;
      m_has_win = 1'b1;
      if (a_valid && b_valid) m_win_b = m_turn_b;
      else if (a_valid)       m_win_b = 1'b0;
      else if (b_valid)       m_win_b = 1'b1;
      else                    m_has_win = 1'b0;
      check("out_valid", out_valid, m_full);
      check("a_ready", a_ready, m_load && m_has_win && !m_win_b);
      check("b_ready", b_ready, m_load && m_has_win && m_win_b);
      if (m_load) begin
        if (m_has_win) begin
          exp_q.push_back('{data: (m_win_b ? b_data : a_data), sel: m_win_b});
          m_full   = 1'b1;
          m_turn_b = !m_win_b;
        end else begin
          m_full = 1'b0;
        end
      end
    end
  end

  // Monitor: every output handshake must match the oldest outstanding expected beat.
  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_idx = exp_q.size();
    end else if (out_valid && out_ready) begin
      if (rd_idx >= exp_q.size()) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_beat: got data %0h sel %0b, expected none", out_data, out_sel);
      end else begin
        check("sb_out_data", out_data, exp_q[rd_idx].data);
        check("sb_out_sel", out_sel, exp_q[rd_idx].sel);
        rd_idx++;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    a_valid = 1'b1; a_data = 8'h55; b_valid = 1'b0; out_ready = 1'b1; rst_n = 1'b0;
    repeat (3) step();
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_data", out_data, 8'h00);
    check("rst_out_sel", out_sel, 1'b0);
    check("rst_a_ready", a_ready, 1'b0);
    check("rst_b_ready", b_ready, 1'b0);
    rst_n = 1'b1;
    step();
    check("first_data", out_data, 8'h55);
    check("first_sel", out_sel, 1'b0);

    // continuous contention
    b_valid = 1'b1; a_data = 8'hA1; b_data = 8'hB2;
    repeat (8) step();

    // backpressure then release with no bubble
    b_valid = 1'b0; a_data = 8'h3C;
    step();
    check("bp_load", out_data, 8'h3C);
    out_ready = 1'b0; a_data = 8'h44;
    for (int i = 0; i < 3; i++) begin
      step();
      check("bp_hold_data", out_data, 8'h3C);
      check("bp_hold_valid", out_valid, 1'b1);
      check("bp_a_ready", a_ready, 1'b0);
      check("bp_b_ready", b_ready, 1'b0);
    end
    out_ready = 1'b1;
    #1 check("bp_release_ready", a_ready, 1'b1);
    step();
    check("bp_next_beat", out_data, 8'h44);

    // single source b, no bubbles
    a_valid = 1'b0; b_valid = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      b_data = 8'(i);
      step();
      check("single_data", out_data, i);
      check("single_sel", out_sel, 1'b1);
      check("single_valid", out_valid, 1'b1);
    end

    // asynchronous reset while FULL
    a_valid = 1'b1; b_valid = 1'b1; a_data = 8'hA1; b_data = 8'hB2; out_ready = 1'b0;
    step();
    #1 rst_n = 1'b0;
    #1;
    check("async_rst_valid", out_valid, 1'b0);
    check("async_rst_data", out_data, 8'h00);
    #1 rst_n = 1'b1;
    out_ready = 1'b1;
    step();
    check("post_rst_first", out_data, 8'hA1);
    check("post_rst_sel0", out_sel, PRIO);
    step();
    check("post_rst_second", out_data, 8'hB2);
    check("post_rst_sel1", out_sel, !PRIO);

    // randomized traffic
    for (int i = 0; i < 1500; i++) begin
      a_valid   = ($urandom_range(0, 3) != 0);
      b_valid   = ($urandom_range(0, 3) != 0);
      a_data    = 8'($urandom);
      b_data    = 8'($urandom);
      out_ready = ($urandom_range(0, 9) < 7);
      step();
    end

    a_valid = 1'b0; b_valid = 1'b0; out_ready = 1'b1;
    repeat (4) step();
    check("drain_all_beats", rd_idx, exp_q.size());
    check("drain_empty", out_valid, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
